// File: rtl/fpmul_generic_pkg.sv
// Shared definitions for the generic floating-point multiplier: FSM states,
// rounding-mode codes, result flag bundle and width-generic constant builders.
package fpmul_generic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_MUL    = 3'd2,
        ST_NORM   = 3'd3,
        ST_ROUND  = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    typedef struct packed {
        logic uf;
        logic of;
        logic nan;
        logic inf;
        logic dn;
        logic zero;
    } flags_t;

    function automatic int bias_of(input int exp_w);
        return (32'sd1 <<< (exp_w - 1)) - 32'sd1;
    endfunction

    // Canonical quiet NaN, positive sign, right-aligned in a 64-bit word.
    function automatic logic [63:0] qnan_word(input int exp_w, input int frac_w);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < exp_w; i++) begin
            v[frac_w + i] = 1'b1;
        end
        v[frac_w - 1] = 1'b1;
        return v;
    endfunction

    // Largest finite magnitude (sign bit excluded).
    function automatic logic [63:0] maxfin_word(input int exp_w, input int frac_w);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < exp_w + frac_w; i++) begin
            v[i] = 1'b1;
        end
        v[frac_w] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/fpmul_generic_round.sv
// Combinational rounding stage: applies the selected rounding mode to a
// normalised significand and decides overflow / underflow of the final exponent.
module fpmul_generic_round
    import fpmul_generic_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [FRAC_W:0]        sig,
    input  logic                   guard,
    input  logic                   rnd,
    input  logic                   sticky,
    input  logic                   sign,
    input  logic [1:0]             rm,
    input  logic signed [EXP_W+1:0] ep,
    output logic [FRAC_W-1:0]      frac,
    output logic signed [EXP_W+1:0] ep_adj,
    output logic                   of,
    output logic                   uf,
    output logic                   of_inf
);

    localparam int EPW = EXP_W + 2;
    localparam logic signed [EPW-1:0] EP_ONE  = {{(EPW-1){1'b0}}, 1'b1};
    localparam logic signed [EPW-1:0] EP_ZERO = {EPW{1'b0}};
    localparam logic signed [EPW-1:0] EP_OF   = {2'b00, {EXP_W{1'b1}}};

    logic               inc_s;
    logic [FRAC_W+1:0]  sum_s;

    // Rounding increment decision and carry renormalisation.
    always_comb begin
        inc_s = 1'b0;
        case (rm)
            RM_RNE:  inc_s = guard & (rnd | sticky | sig[0]);
            RM_RTZ:  inc_s = 1'b0;
            RM_RUP:  inc_s = ~sign & (guard | rnd | sticky);
            RM_RDN:  inc_s = sign & (guard | rnd | sticky);
            default: inc_s = 1'b0;
        endcase
        sum_s = {1'b0, sig} + {{(FRAC_W+1){1'b0}}, inc_s};
        if (sum_s[FRAC_W+1]) begin
            frac   = sum_s[FRAC_W:1];
            ep_adj = ep + EP_ONE;
        end else begin
            frac   = sum_s[FRAC_W-1:0];
            ep_adj = ep;
        end
    end

    // Range check; overflow saturates to Inf only when rounding points away from zero.
    always_comb begin
        of     = (ep_adj >= EP_OF);
        uf     = ~of & (ep_adj <= EP_ZERO);
        of_inf = 1'b0;
        case (rm)
            RM_RNE:  of_inf = 1'b1;
            RM_RTZ:  of_inf = 1'b0;
            RM_RUP:  of_inf = ~sign;
            RM_RDN:  of_inf = sign;
            default: of_inf = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpmul_generic.sv
// Multi-cycle parametrised floating-point multiplier with Busy/Done handshake,
// radix-2 shift-add significand core and four rounding modes.
module fpmul_generic
    import fpmul_generic_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Start,
    input  logic [1:0]                    RM,
    input  logic [EXP_W+FRAC_W:0]         A,
    input  logic [EXP_W+FRAC_W:0]         B,
    output logic                          Busy,
    output logic                          Done,
    output logic [EXP_W+FRAC_W:0]         P,
    output logic                          UF,
    output logic                          OF,
    output logic                          NaNF,
    output logic                          InfF,
    output logic                          DNF,
    output logic                          ZF
);

    localparam int W    = 1 + EXP_W + FRAC_W;
    localparam int EPW  = EXP_W + 2;
    localparam int SIGW = FRAC_W + 1;
    localparam int PW   = 2 * SIGW;
    localparam int CNTW = $clog2(SIGW + 1);

    localparam logic [W-1:0]           QNAN     = W'(qnan_word(EXP_W, FRAC_W));
    localparam logic [W-1:0]           MAXFIN   = W'(maxfin_word(EXP_W, FRAC_W));
    localparam logic signed [EPW-1:0]  BIAS_EP  = EPW'(bias_of(EXP_W));
    localparam logic signed [EPW-1:0]  EP_ONE   = {{(EPW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]        CNT_LAST = CNTW'(FRAC_W);
    localparam logic [CNTW-1:0]        CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]        CNT_ZERO = {CNTW{1'b0}};

    state_e                  state_r;
    logic [W-1:0]            a_r, b_r;
    logic [1:0]              rm_r;
    logic                    sp_r;
    logic [EXP_W-1:0]        ea_r, eb_r;
    logic [PW-1:0]           acc_r, mcand_r;
    logic [SIGW-1:0]         mplier_r;
    logic [CNTW-1:0]         cnt_r;
    logic signed [EPW-1:0]   ep_r;
    logic [SIGW-1:0]         sig_r;
    logic                    g_r, r_r, s_r;
    logic [W-1:0]            res_r;
    flags_t                  flags_r;
    logic                    busy_r, done_r;
    logic [W-1:0]            p_r;
    flags_t                  flg_r;

    logic [EXP_W-1:0]        ea_s, eb_s;
    logic [FRAC_W-1:0]       fa_s, fb_s;
    logic                    sp_s, nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;
    logic                    special_s;
    logic [W-1:0]            dec_res_s;
    flags_t                  dec_flags_s;

    logic                    norm_hi_s;
    logic [SIGW-1:0]         norm_sig_s;
    logic                    norm_g_s, norm_r_s, norm_s_s;

    logic [FRAC_W-1:0]       rnd_frac_s;
    logic signed [EPW-1:0]   rnd_ep_s;
    logic                    rnd_of_s, rnd_uf_s, rnd_inf_s;

    // Operand classification; denormals behave as zeros and raise DN.
    always_comb begin
        ea_s     = a_r[W-2:FRAC_W];
        eb_s     = b_r[W-2:FRAC_W];
        fa_s     = a_r[FRAC_W-1:0];
        fb_s     = b_r[FRAC_W-1:0];
        sp_s     = a_r[W-1] ^ b_r[W-1];
        nan_a_s  = (&ea_s) & (|fa_s);
        nan_b_s  = (&eb_s) & (|fb_s);
        inf_a_s  = (&ea_s) & ~(|fa_s);
        inf_b_s  = (&eb_s) & ~(|fb_s);
        zero_a_s = ~(|ea_s);
        zero_b_s = ~(|eb_s);
        dec_flags_s    = '0;
        dec_flags_s.dn = (zero_a_s & (|fa_s)) | (zero_b_s & (|fb_s));
        dec_res_s      = {W{1'b0}};
        special_s      = 1'b1;
        if (nan_a_s | nan_b_s | (inf_a_s & zero_b_s) | (inf_b_s & zero_a_s)) begin
            dec_res_s       = QNAN;
            dec_flags_s.nan = 1'b1;
        end else if (inf_a_s | inf_b_s) begin
            dec_res_s       = {sp_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            dec_flags_s.inf = 1'b1;
        end else if (zero_a_s | zero_b_s) begin
            dec_res_s        = {sp_s, {(W-1){1'b0}}};
            dec_flags_s.zero = 1'b1;
        end else begin
            special_s = 1'b0;
        end
    end

    // Normalisation view of the raw product: select window, guard, round and sticky.
    always_comb begin
        norm_hi_s = acc_r[PW-1];
        if (norm_hi_s) begin
            norm_sig_s = acc_r[PW-1:FRAC_W+1];
            norm_g_s   = acc_r[FRAC_W];
            norm_r_s   = acc_r[FRAC_W-1];
            norm_s_s   = |acc_r[FRAC_W-2:0];
        end else begin
            norm_sig_s = acc_r[PW-2:FRAC_W];
            norm_g_s   = acc_r[FRAC_W-1];
            norm_r_s   = acc_r[FRAC_W-2];
            norm_s_s   = |acc_r[FRAC_W-3:0];
        end
    end

    fpmul_generic_round #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round (
        .sig    (sig_r),
        .guard  (g_r),
        .rnd    (r_r),
        .sticky (s_r),
        .sign   (sp_r),
        .rm     (rm_r),
        .ep     (ep_r),
        .frac   (rnd_frac_s),
        .ep_adj (rnd_ep_s),
        .of     (rnd_of_s),
        .uf     (rnd_uf_s),
        .of_inf (rnd_inf_s)
    );

    // Control FSM together with the datapath registers it sequences.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r  <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            rm_r     <= 2'b00;
            sp_r     <= 1'b0;
            ea_r     <= '0;
            eb_r     <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            ep_r     <= '0;
            sig_r    <= '0;
            g_r      <= 1'b0;
            r_r      <= 1'b0;
            s_r      <= 1'b0;
            res_r    <= '0;
            flags_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            p_r      <= '0;
            flg_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        a_r     <= A;
                        b_r     <= B;
                        rm_r    <= RM;
                        busy_r  <= 1'b1;
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    sp_r     <= sp_s;
                    ea_r     <= ea_s;
                    eb_r     <= eb_s;
                    acc_r    <= '0;
                    mcand_r  <= {{SIGW{1'b0}}, 1'b1, fa_s};
                    mplier_r <= {1'b1, fb_s};
                    cnt_r    <= CNT_ZERO;
                    res_r    <= dec_res_s;
                    flags_r  <= dec_flags_s;
                    state_r  <= special_s ? ST_FIN : ST_MUL;
                end
                ST_MUL: begin
                    if (cnt_r == CNT_ZERO) begin
                        ep_r <= $signed({2'b00, ea_r}) + $signed({2'b00, eb_r}) - BIAS_EP;
                    end
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    sig_r   <= norm_sig_s;
                    g_r     <= norm_g_s;
                    r_r     <= norm_r_s;
                    s_r     <= norm_s_s;
                    ep_r    <= norm_hi_s ? (ep_r + EP_ONE) : ep_r;
                    state_r <= ST_ROUND;
                end
                ST_ROUND: begin
                    ep_r    <= rnd_ep_s;
                    flags_r <= '0;
                    if (rnd_of_s) begin
                        flags_r.of  <= 1'b1;
                        flags_r.inf <= rnd_inf_s;
                        res_r <= rnd_inf_s ? {sp_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                                           : {sp_r, MAXFIN[W-2:0]};
                    end else if (rnd_uf_s) begin
                        flags_r.uf   <= 1'b1;
                        flags_r.zero <= 1'b1;
                        flags_r.dn   <= 1'b1;
                        res_r        <= {sp_r, {(W-1){1'b0}}};
                    end else begin
                        res_r <= {sp_r, rnd_ep_s[EXP_W-1:0], rnd_frac_s};
                    end
                    state_r <= ST_FIN;
                end
                ST_FIN: begin
                    p_r     <= res_r;
                    flg_r   <= flags_r;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy = busy_r;
    assign Done = done_r;
    assign P    = p_r;
    assign UF   = flg_r.uf;
    assign OF   = flg_r.of;
    assign NaNF = flg_r.nan;
    assign InfF = flg_r.inf;
    assign DNF  = flg_r.dn;
    assign ZF   = flg_r.zero;

endmodule
